// File: rtl/max7219_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// max7219_frame_scheduler_if
//   Bundles the request, frame and serializer handshake signals of the
//   MAX7219 frame scheduler.
//
//   init_req   : one-cycle pulse, run the configuration sequence
//   start      : one-cycle pulse, send a frame (8 row commands)
//   intensity  : brightness code sent in the 0xA command
//   frame_data : frame, row r of matrix m at [m*64 + r*8 +: 8]
//   ser_data   : one 16-bit command word per matrix, word m at [m*16 +: 16]
//   ser_val    : ser_data is valid
//   ser_rdy    : serializer accepts the word this cycle
//   busy       : a sequence is in progress
//   done       : one-cycle pulse when a sequence completes
//
//   master : the scheduler side
//   slave  : the requester / serializer side
// ---------------------------------------------------------------------------
interface max7219_frame_scheduler_if #(
  parameter int G_NB_MATRIX = 2
);
  logic                      init_req;
  logic                      start;
  logic [3:0]                intensity;
  logic [G_NB_MATRIX*64-1:0] frame_data;
  logic [G_NB_MATRIX*16-1:0] ser_data;
  logic                      ser_val;
  logic                      ser_rdy;
  logic                      busy;
  logic                      done;

  modport master (
    input  init_req, start, intensity, frame_data, ser_rdy,
    output ser_data, ser_val, busy, done
  );

  modport slave (
    output init_req, start, intensity, frame_data, ser_rdy,
    input  ser_data, ser_val, busy, done
  );
endinterface

// File: rtl/max7219_frame_scheduler.sv
// ---------------------------------------------------------------------------
// max7219_frame_scheduler
//   Sequences command words for a chain of G_NB_MATRIX cascaded MAX7219
//   8x8 matrices (legal range 1..8). An init request sends the five
//   configuration commands (same word on every matrix lane); a start
//   request sends the eight digit-register commands of a captured frame.
//   An init and start arriving together run configuration then the frame
//   back to back with a single done pulse.
//
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-high reset, aborts any sequence in flight
//     bus : max7219_frame_scheduler_if.master (requests, frame, serializer
//           valid/ready handshake, busy/done status)
// ---------------------------------------------------------------------------
module max7219_frame_scheduler #(
  parameter int G_NB_MATRIX = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  max7219_frame_scheduler_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    ROW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] CFG_LAST = 4'd4;
  localparam logic [3:0] ROW_LAST = 4'd7;

  state_t                    state_reg, state_next;
  logic [3:0]                idx_reg, idx_next;
  logic                      pending_reg, pending_next;
  logic [3:0]                intensity_reg;
  logic [G_NB_MATRIX*64-1:0] frame_reg;
  logic                      load_intensity;
  logic                      load_frame;
  logic                      xfer;
  logic [15:0]               cfg_word;
  logic [G_NB_MATRIX*16-1:0] ser_data_w;

  // Commands are presented straight from state, so ser_val stays high and
  // ser_data stays constant until the word is accepted.
  assign bus.ser_val = (state_reg == CFG) || (state_reg == ROW);
  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = (state_reg == DONE);
  assign xfer        = bus.ser_val && bus.ser_rdy;

  // ------------------------------------------------------------------ state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 4'd0;
      pending_reg   <= 1'b0;
      intensity_reg <= 4'd0;
      frame_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
      if (load_intensity) begin
        intensity_reg <= bus.intensity;
      end
      if (load_frame) begin
        frame_reg <= bus.frame_data;
      end
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    pending_next   = pending_reg;
    load_intensity = 1'b0;
    load_frame     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.init_req) begin
          state_next     = CFG;
          idx_next       = 4'd0;
          load_intensity = 1'b1;
          // A simultaneous start is remembered and served right after CFG.
          pending_next   = bus.start;
        end else if (bus.start) begin
          state_next = ROW;
          idx_next   = 4'd0;
          load_frame = 1'b1;
        end
      end

      CFG: begin
        if (xfer) begin
          if (idx_reg == CFG_LAST) begin
            idx_next = 4'd0;
            if (pending_reg) begin
              state_next   = ROW;
              load_frame   = 1'b1;
              pending_next = 1'b0;
            end else begin
              state_next = DONE;
            end
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end

      ROW: begin
        if (xfer) begin
          if (idx_reg == ROW_LAST) begin
            state_next = DONE;
            idx_next   = 4'd0;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end

      DONE: begin
        // Requests arriving here are dropped, not queued.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------- command words
  always_comb begin
    cfg_word = 16'h0000;
    unique case (idx_reg)
      4'd0:    cfg_word = 16'h0C01;                 // shutdown reg: normal operation
      4'd1:    cfg_word = 16'h0900;                 // decode mode: none
      4'd2:    cfg_word = 16'h0B07;                 // scan limit: all 8 digits
      4'd3:    cfg_word = {12'h0A0, intensity_reg}; // intensity
      4'd4:    cfg_word = 16'h0F00;                 // display test off
      default: cfg_word = 16'h0000;
    endcase
  end

  generate
    for (genvar gi = 0; gi < G_NB_MATRIX; gi++) begin : g_lane
      logic [7:0] row_byte;

      // Digit registers are 1..8, so row r goes to address r+1.
      assign row_byte = frame_reg[gi*64 + {idx_reg[2:0], 3'b000} +: 8];

      assign ser_data_w[gi*16 +: 16] =
          (state_reg == CFG) ? cfg_word :
          (state_reg == ROW) ? {4'h0, idx_reg + 4'd1, row_byte} :
                               16'h0000;
    end
  endgenerate

  assign bus.ser_data = ser_data_w;

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_max7219_frame_scheduler
//   Self-checking bench for max7219_frame_scheduler with two matrices.
//   A negedge monitor records every accepted word; each test task builds
//   the expected word list from the command rules and compares.
// ---------------------------------------------------------------------------
module tb_max7219_frame_scheduler;
  localparam int NB = 2;
  typedef logic [NB*16-1:0] word_t;
  typedef logic [NB*64-1:0] frame_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  max7219_frame_scheduler_if #(.G_NB_MATRIX(NB)) bus_if ();

  max7219_frame_scheduler #(.G_NB_MATRIX(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int    pass_cnt = 0;
  int    check_cnt = 0;
  int    cyc = 0;
  word_t obs_q[$];
  int    obs_cyc_q[$];
  word_t exp_q[$];
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    busy_cnt = 0;
  int    zero_viol = 0;
  int    hold_viol = 0;
  logic  prev_stall = 1'b0;
  word_t prev_data = '0;

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (bus_if.ser_val === 1'b0 && bus_if.ser_data !== '0) zero_viol++;
    if (prev_stall && (bus_if.ser_val !== 1'b1 || bus_if.ser_data !== prev_data)) hold_viol++;
    prev_stall = (bus_if.ser_val === 1'b1) && (bus_if.ser_rdy === 1'b0);
    prev_data  = bus_if.ser_data;
    if (bus_if.ser_val === 1'b1 && bus_if.ser_rdy === 1'b1) begin
      obs_q.push_back(bus_if.ser_data);
      obs_cyc_q.push_back(cyc);
      $display("xfer cyc=%0d ser_data=%h", cyc, bus_if.ser_data);
    end
    if (bus_if.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus_if.busy === 1'b1) busy_cnt++;
    cyc++;
  end

  // ------------------------------------------------------- reference model
  function automatic word_t replicate(input logic [15:0] w);
    word_t v;
    for (int m = 0; m < NB; m++) v[m*16 +: 16] = w;
    return v;
  endfunction

  function automatic void push_cfg(input logic [3:0] inten);
    logic [15:0] cmds[5];
    cmds = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A00 + 16'(inten), 16'h0F00};
    for (int i = 0; i < 5; i++) exp_q.push_back(replicate(cmds[i]));
  endfunction

  function automatic void push_frame(input frame_t f);
    word_t v;
    for (int r = 0; r < 8; r++) begin
      for (int m = 0; m < NB; m++) begin
        v[m*16 +: 16] = 16'((r + 1) * 256 + int'(f[m*64 + r*8 +: 8]));
      end
      exp_q.push_back(v);
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= obs_q.size() || i >= exp_q.size()) return i;
      if (obs_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic word_t obs_at(input int i);
    return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 'x;
  endfunction

  function automatic word_t exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 'x;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NB*2; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  function automatic frame_t pattern_frame();
    frame_t f;
    for (int r = 0; r < 8; r++) begin
      f[r*8 +: 8]      = 8'(8'h10 + r);
      f[64 + r*8 +: 8] = 8'(8'hA0 + r);
    end
    return f;
  endfunction

  // ------------------------------------------------------------- utilities
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic pulse(input logic i, input logic s);
    @(posedge clk);
    #1;
    bus_if.init_req = i;
    bus_if.start    = s;
    @(posedge clk);
    #1;
    bus_if.init_req = 1'b0;
    bus_if.start    = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd, output bit ok);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < max_cyc) begin
      @(posedge clk);
      #1;
      if (rnd) bus_if.ser_rdy = 1'($urandom_range(0, 1));
      n++;
    end
    bus_if.ser_rdy = 1'b1;
    ok = (done_cnt != base);
  endtask

  task automatic wait_words(input int nw, input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (obs_q.size() < nw && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (obs_q.size() >= nw);
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    #2;
    check_cnt++;
    if (bus_if.ser_val !== 1'b0) $display("FAIL reset_ser_val: got %b expected 0", bus_if.ser_val);
    else pass_cnt++;
    check_cnt++;
    if (bus_if.ser_data !== '0) $display("FAIL reset_ser_data: got %h expected 0", bus_if.ser_data);
    else pass_cnt++;
    check_cnt++;
    if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
    else pass_cnt++;
    check_cnt++;
    if (bus_if.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus_if.done);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_cfg();
    bit ok;
    int d;
    clear_obs();
    bus_if.ser_rdy   = 1'b1;
    bus_if.intensity = 4'h5;
    push_cfg(4'h5);
    pulse(1'b1, 1'b0);
    // intensity must have been sampled on the entry edge only
    bus_if.intensity = 4'($urandom_range(6, 15));
    wait_done(40, 1'b0, ok);
    idle(2);
    check_cnt++;
    if (!ok) $display("FAIL cfg_timeout: got no done expected done");
    else pass_cnt++;
    d = first_diff();
    check_cnt++;
    if (d >= 0) $display("FAIL cfg_stream: word %0d got %h expected %h (%0d/%0d words)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    else pass_cnt++;
    check_cnt++;
    if (obs_cyc_q.size() != 5 || obs_cyc_q[4] - obs_cyc_q[0] != 4)
      $display("FAIL cfg_consecutive: got %0d words not on 5 consecutive cycles expected 5 consecutive", obs_cyc_q.size());
    else pass_cnt++;
    check_cnt++;
    if (obs_cyc_q.size() != 5 || done_cyc != obs_cyc_q[4] + 1)
      $display("FAIL cfg_done_timing: got done cycle %0d expected one after last word", done_cyc);
    else pass_cnt++;
    check_cnt++;
    if (busy_cnt != 6) $display("FAIL cfg_busy_cycles: got %0d expected 6", busy_cnt);
    else pass_cnt++;
    check_cnt++;
    if (done_cnt != 1) $display("FAIL cfg_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_row();
    bit ok;
    int d;
    clear_obs();
    bus_if.frame_data = pattern_frame();
    push_frame(pattern_frame());
    pulse(1'b0, 1'b1);
    wait_words(8, 60, ok);
    // now in the DONE cycle: these requests must be dropped
    bus_if.start    = 1'b1;
    bus_if.init_req = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start    = 1'b0;
    bus_if.init_req = 1'b0;
    idle(20);
    check_cnt++;
    if (!ok) $display("FAIL row_timeout: got %0d words expected 8", obs_q.size());
    else pass_cnt++;
    d = first_diff();
    check_cnt++;
    if (d >= 0) $display("FAIL row_stream: word %0d got %h expected %h (%0d/%0d words)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    else pass_cnt++;
    check_cnt++;
    if (obs_at(0) !== 32'h01A0_0110) $display("FAIL row_r0: got %h expected 01a00110", obs_at(0));
    else pass_cnt++;
    check_cnt++;
    if (obs_at(7) !== 32'h08A7_0817) $display("FAIL row_r7: got %h expected 08a70817", obs_at(7));
    else pass_cnt++;
    check_cnt++;
    if (done_cnt != 1) $display("FAIL row_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
    check_cnt++;
    if (obs_cyc_q.size() < 8 || done_cyc != obs_cyc_q[7] + 1)
      $display("FAIL row_done_timing: got done cycle %0d expected one after last word", done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int d;
    int r3;
    clear_obs();
    bus_if.ser_rdy    = 1'b1;
    bus_if.frame_data = pattern_frame();
    push_frame(pattern_frame());
    pulse(1'b0, 1'b1);
    wait_words(3, 60, ok);
    check_cnt++;
    if (!ok) $display("FAIL bp_reach_r3: got %0d words expected 3", obs_q.size());
    else pass_cnt++;
    bus_if.ser_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_cnt++;
      if (bus_if.ser_val !== 1'b1 || bus_if.ser_data !== 32'h04A3_0413)
        $display("FAIL bp_hold_%0d: got val=%b data=%h expected val=1 data=04a30413", k, bus_if.ser_val, bus_if.ser_data);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    bus_if.ser_rdy = 1'b1;
    wait_done(40, 1'b0, ok);
    idle(2);
    d = first_diff();
    check_cnt++;
    if (d >= 0) $display("FAIL bp_stream: word %0d got %h expected %h (%0d/%0d words)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    else pass_cnt++;
    r3 = 0;
    foreach (obs_q[i]) if (obs_q[i] === 32'h04A3_0413) r3++;
    check_cnt++;
    if (r3 != 1) $display("FAIL bp_r3_count: got %0d expected 1", r3);
    else pass_cnt++;
    check_cnt++;
    if (obs_cyc_q.size() < 4 || obs_cyc_q[3] - obs_cyc_q[2] != 11)
      $display("FAIL bp_stall_len: got %0d words expected r3 accepted 11 cycles after r2", obs_cyc_q.size());
    else pass_cnt++;
    check_cnt++;
    if (hold_viol != 0) $display("FAIL bp_stable: got %0d hold violations expected 0", hold_viol);
    else pass_cnt++;
  endtask

  task automatic test_init_and_start();
    bit ok;
    int d;
    logic [3:0] inten;
    frame_t fb;
    clear_obs();
    inten = 4'($urandom);
    bus_if.intensity  = inten;
    bus_if.frame_data = rand_frame();
    push_cfg(inten);
    pulse(1'b1, 1'b1);
    // frame is captured at CFG->ROW, so the value present then is expected
    fb = rand_frame();
    bus_if.frame_data = fb;
    push_frame(fb);
    wait_words(8, 60, ok);
    bus_if.start    = 1'b1;
    bus_if.init_req = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start      = 1'b0;
    bus_if.init_req   = 1'b0;
    bus_if.frame_data = rand_frame();
    wait_done(60, 1'b0, ok);
    idle(20);
    check_cnt++;
    if (!ok) $display("FAIL both_timeout: got no done expected done");
    else pass_cnt++;
    d = first_diff();
    check_cnt++;
    if (d >= 0) $display("FAIL both_stream: word %0d got %h expected %h (%0d/%0d words)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    else pass_cnt++;
    check_cnt++;
    if (done_cnt != 1) $display("FAIL both_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
    check_cnt++;
    if (obs_cyc_q.size() != 13 || obs_cyc_q[12] - obs_cyc_q[0] != 12)
      $display("FAIL both_back_to_back: got %0d words expected 13 on consecutive cycles", obs_cyc_q.size());
    else pass_cnt++;
    check_cnt++;
    if (busy_cnt != 14) $display("FAIL both_busy_cycles: got %0d expected 14", busy_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    frame_t f;
    clear_obs();
    f = rand_frame();
    bus_if.frame_data = f;
    pulse(1'b0, 1'b1);
    wait_words(5, 60, ok);
    rst = 1'b1;
    #1;
    check_cnt++;
    if (bus_if.ser_val !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.ser_data !== '0)
      $display("FAIL rstmid_abort: got val=%b busy=%b data=%h expected 0 0 0", bus_if.ser_val, bus_if.busy, bus_if.ser_data);
    else pass_cnt++;
    idle(3);
    check_cnt++;
    if (done_cnt != 0 || obs_q.size() != 5)
      $display("FAIL rstmid_no_done: got done=%0d words=%0d expected 0 and 5", done_cnt, obs_q.size());
    else pass_cnt++;
    clear_obs();
    push_frame(f);
    // request on the very first edge after release
    rst = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    wait_done(40, 1'b0, ok);
    idle(2);
    d = first_diff();
    check_cnt++;
    if (d >= 0) $display("FAIL rstmid_replay: word %0d got %h expected %h (%0d/%0d words)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    else pass_cnt++;
    check_cnt++;
    if (done_cnt != 1) $display("FAIL rstmid_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_capture();
    bit ok;
    int d;
    frame_t fa;
    clear_obs();
    fa = rand_frame();
    bus_if.frame_data = fa;
    push_frame(fa);
    pulse(1'b0, 1'b1);
    bus_if.frame_data = ~fa;
    wait_done(300, 1'b1, ok);
    idle(2);
    check_cnt++;
    if (!ok) $display("FAIL capture_timeout: got no done expected done");
    else pass_cnt++;
    d = first_diff();
    check_cnt++;
    if (d >= 0) $display("FAIL capture_stream: word %0d got %h expected %h (%0d/%0d words)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    else pass_cnt++;
    check_cnt++;
    if (hold_viol != 0) $display("FAIL capture_stable: got %0d hold violations expected 0", hold_viol);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    int kind;
    logic [3:0] inten;
    frame_t f;
    for (int k = 0; k < 6; k++) begin
      clear_obs();
      kind  = $urandom_range(0, 2);
      inten = 4'($urandom);
      f     = rand_frame();
      bus_if.intensity  = inten;
      bus_if.frame_data = f;
      if (kind != 1) push_cfg(inten);
      if (kind != 0) push_frame(f);
      pulse(kind != 1, kind != 0);
      wait_done(400, 1'b1, ok);
      check_cnt++;
      if (!ok) $display("FAIL b2b_timeout_%0d: got no done expected done", k);
      else pass_cnt++;
      d = first_diff();
      check_cnt++;
      if (d >= 0) $display("FAIL b2b_stream_%0d: word %0d got %h expected %h (%0d/%0d words)", k, d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      else pass_cnt++;
      check_cnt++;
      if (done_cnt != 1) $display("FAIL b2b_done_count_%0d: got %0d expected 1", k, done_cnt);
      else pass_cnt++;
    end
    check_cnt++;
    if (zero_viol != 0) $display("FAIL idle_data_zero: got %0d nonzero idle words expected 0", zero_viol);
    else pass_cnt++;
    check_cnt++;
    if (hold_viol != 0) $display("FAIL b2b_stable: got %0d hold violations expected 0", hold_viol);
    else pass_cnt++;
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    rst               = 1'b1;
    bus_if.init_req   = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.intensity  = 4'h0;
    bus_if.frame_data = '0;
    bus_if.ser_rdy    = 1'b1;
    test_reset();
    test_cfg();
    test_row();
    test_backpressure();
    test_init_and_start();
    test_reset_mid();
    test_capture();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
